timer_arb: RTL
==============

TIMER_ARB -- requirements
Module: timer_arb

Interface
REQ-001 Parameter LOCK_MAX, 4: maximum consecutive transactions port 0 keeps the grant under lock; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 m0_ift  Mem_ift.Slave  --  requester 0 (core data port).
REQ-005 m1_ift  Mem_ift.Slave  --  requester 1 (debug/DMA port).
REQ-006 s_ift  Mem_ift.Master  --  downstream timer MMIO slave.
REQ-007 lock0  input  1  requester 0 asks to retain the grant (compiled only with TIMER_ARB_LOCK_EN).
REQ-008 busy  output  1  high whenever state is not IDLE.

Function
REQ-009 A request is ren|wen on a port; the requester SHALL hold the address, data and mask stable until it sees its rvalid or wvalid pulse.
REQ-010 States: IDLE, ISSUE, RESP; encoding lives in the package.
REQ-011 IDLE: if any request, pick a winner, latch its ren, wen, raddr, waddr, wdata and wmask into a holding register, record the grant, and go to ISSUE; otherwise stay in IDLE.
REQ-012 Arbitration: only one requester means that requester wins; when both request, the winner is the port not granted last; after reset, port 0 counts as last granted, so port 1 wins the first tie.
REQ-013 ISSUE: drive the holding register onto s_ift for exactly one cycle, capture s_ift rdata, and go to RESP; s_ift ren/wen SHALL be 0 in every other state.
REQ-014 RESP: assert rvalid (for a read) or wvalid (for a write) to the granted port for exactly one cycle, with rdata equal to the captured value, then go to IDLE.
REQ-015 The non-granted port SHALL see rvalid=0, wvalid=0 and rdata=0 at all times; the granted port sees these values outside RESP.
REQ-016 Fixed latency: request sampled in IDLE at edge N, downstream access during cycle N+1, response pulse during cycle N+2, next arbitration at edge N+3.
REQ-017 ren and wen both high on one port is a single transaction; the write is forwarded and wvalid is returned, and the read is dropped.
REQ-018 A request withdrawn after it is latched still completes downstream; its response pulse is still issued and is ignored.
REQ-019 The pending request of the losing port is not latched; it is re-evaluated in the next IDLE cycle, and the round-robin rule bounds its wait to one transaction.

Reset
REQ-020 While rstn is low: state IDLE, holding register 0, last-grant set to port 0, lock counter 0.
REQ-021 While rstn is low: all s_ift outputs 0, all requester rvalid/wvalid/rdata 0, busy 0.
REQ-022 Reset asserted mid-transaction aborts it with no response pulse; the downstream write is lost if reset arrives before the ISSUE edge.

Configuration
REQ-023 Macro TIMER_ARB_LOCK_EN.
REQ-024 With the macro defined: lock0=1 with a port 0 request in IDLE grants port 0 regardless of round-robin and increments a 4-bit lock counter.
REQ-025 With the macro defined: after LOCK_MAX consecutive locked grants, or whenever lock0=0 in IDLE, the counter clears and normal round-robin resumes.
REQ-026 With the macro undefined: the lock0 port and the counter are absent and behaviour is pure round-robin.

Structure
REQ-027 Package TimerArbStruct SHALL hold the state enum and the holding-register packed struct (ren, wen, raddr[63:0], waddr[63:0], wdata[63:0], wmask[7:0]).
REQ-028 Sub-module rr_arb2: combinational two-way round-robin pick, with inputs req[1:0], last and lock_force, and output gnt[1:0] one-hot or zero.

Verification
REQ-029 Port 0 writes `MTIMECMP_BASE with wdata=0x100 and wmask=0xFF -> s_ift wen for one cycle at N+1, m0 wvalid at N+2; a subsequent read returns 0x100.
REQ-030 Both ports read `MTIME_BASE at the same edge after reset -> port 1 is served first; port 0 gets rvalid exactly 3 cycles later.
REQ-031 Port 1 requests continuously and port 0 requests once -> port 0 is served within 3 cycles of its first IDLE; no double grant.
REQ-032 rstn is pulsed low during ISSUE of a port 0 write -> no wvalid, mtimecmp is unchanged, and busy=0 on the asynchronous assert.
REQ-033 With TIMER_ARB_LOCK_EN, lock0=1, both ports requesting continuously, LOCK_MAX=4 -> port 0 gets 4 grants, then port 1 gets 1 grant.
REQ-034 Port 0 asserts ren and wen together to `MTIMECMP_BASE -> only the write is forwarded, wvalid is returned, and rvalid stays 0.

Source files
------------

// File: rtl/timer_arb_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// TimerArbStruct -- FSM state and holding-register types for timer_arb. Rev 1.0
// -----------------------------------------------------------------------------
package TimerArbStruct;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [63:0] raddr;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } hold_t;

  // A combined read+write request collapses to the write alone.
  function automatic hold_t pack_req(input logic        ren,
                                     input logic        wen,
                                     input logic [63:0] raddr,
                                     input logic [63:0] waddr,
                                     input logic [63:0] wdata,
                                     input logic [7:0]  wmask);
    hold_t h;
    h.ren   = ren & ~wen;
    h.wen   = wen;
    h.raddr = raddr;
    h.waddr = waddr;
    h.wdata = wdata;
    h.wmask = wmask;
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_arb_rr_arb2.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rr_arb2 -- combinational two-way round-robin pick with port-0 lock override.
// Rev 1.0
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_force,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (lock_force && req[0]) begin
      gnt = 2'b01;
    end else begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // On a tie the port that was not granted last wins.
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_arb.sv
`default_nettype none
// -----------------------------------------------------------------------------
// timer_arb -- arbitrates two requesters onto one timer MMIO slave, fixed
// 3-cycle turnaround. Port-0 grant lock built with TIMER_ARB_LOCK_EN. Rev 1.0
// -----------------------------------------------------------------------------
module timer_arb
  import TimerArbStruct::*;
#(
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        m0_ren,
  input  logic        m0_wen,
  input  logic [63:0] m0_raddr,
  input  logic [63:0] m0_waddr,
  input  logic [63:0] m0_wdata,
  input  logic [7:0]  m0_wmask,
  output logic [63:0] m0_rdata,
  output logic        m0_rvalid,
  output logic        m0_wvalid,

  input  logic        m1_ren,
  input  logic        m1_wen,
  input  logic [63:0] m1_raddr,
  input  logic [63:0] m1_waddr,
  input  logic [63:0] m1_wdata,
  input  logic [7:0]  m1_wmask,
  output logic [63:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        m1_wvalid,

  output logic        s_ren,
  output logic        s_wen,
  output logic [63:0] s_raddr,
  output logic [63:0] s_waddr,
  output logic [63:0] s_wdata,
  output logic [7:0]  s_wmask,
  input  logic [63:0] s_rdata,

`ifdef TIMER_ARB_LOCK_EN
  input  logic        lock0,
`endif
  output logic        busy
);

  state_e      state_q, state_d;
  hold_t       hold_q, hold_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        s_ren_q, s_ren_d;
  logic        s_wen_q, s_wen_d;
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m0_wvalid_q, m0_wvalid_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic        m1_wvalid_q, m1_wvalid_d;
  logic [63:0] m0_rdata_q, m0_rdata_d;
  logic [63:0] m1_rdata_q, m1_rdata_d;
  logic        busy_q, busy_d;

  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        lock_force;

  assign req = {m1_ren | m1_wen, m0_ren | m0_wen};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last       (last_q),
    .lock_force (lock_force),
    .gnt        (gnt)
  );

`ifdef TIMER_ARB_LOCK_EN
  localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_MAX);

  logic [3:0] lock_cnt_q, lock_cnt_d;

  assign lock_force = lock0 && (lock_cnt_q < LOCK_LIMIT);

  // Counter only moves on arbitration cycles; an exhausted run clears it so
  // the same IDLE cycle falls back to round-robin.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (state_q == ST_IDLE) begin
      if (!lock0 || (lock_cnt_q >= LOCK_LIMIT)) begin
        lock_cnt_d = 4'd0;
      end else if (lock_force && req[0]) begin
        lock_cnt_d = lock_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_cnt_q <= 4'd0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  // No lock hardware in this build; LOCK_MAX is referenced but has no effect.
  assign lock_force = 1'b0 & (LOCK_MAX != 0);
`endif

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    s_ren_d     = 1'b0;
    s_wen_d     = 1'b0;
    m0_rvalid_d = 1'b0;
    m0_wvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m1_wvalid_d = 1'b0;
    m0_rdata_d  = 64'd0;
    m1_rdata_d  = 64'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          gnt_d   = gnt[1];
          last_d  = gnt[1];
          hold_d  = gnt[1] ? pack_req(m1_ren, m1_wen, m1_raddr, m1_waddr, m1_wdata, m1_wmask)
                           : pack_req(m0_ren, m0_wen, m0_raddr, m0_waddr, m0_wdata, m0_wmask);
          s_ren_d = hold_d.ren;
          s_wen_d = hold_d.wen;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
        if (gnt_q) begin
          m1_rvalid_d = hold_q.ren;
          m1_wvalid_d = hold_q.wen;
          m1_rdata_d  = s_rdata;
        end else begin
          m0_rvalid_d = hold_q.ren;
          m0_wvalid_d = hold_q.wen;
          m0_rdata_d  = s_rdata;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      gnt_q       <= 1'b0;
      last_q      <= 1'b0;
      s_ren_q     <= 1'b0;
      s_wen_q     <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m0_wvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m1_wvalid_q <= 1'b0;
      m0_rdata_q  <= 64'd0;
      m1_rdata_q  <= 64'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      s_ren_q     <= s_ren_d;
      s_wen_q     <= s_wen_d;
      m0_rvalid_q <= m0_rvalid_d;
      m0_wvalid_q <= m0_wvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m1_wvalid_q <= m1_wvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign s_ren     = s_ren_q;
  assign s_wen     = s_wen_q;
  assign s_raddr   = hold_q.raddr;
  assign s_waddr   = hold_q.waddr;
  assign s_wdata   = hold_q.wdata;
  assign s_wmask   = hold_q.wmask;
  assign m0_rvalid = m0_rvalid_q;
  assign m0_wvalid = m0_wvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m1_wvalid = m1_wvalid_q;
  assign m1_rdata  = m1_rdata_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire
